// File: rtl/asic_skidbuf.sv
// Two-entry valid/ready skid buffer: registers the forward valid/data path and
// the reverse ready path so long routes can be cut in both directions.
module asic_skidbuf #(
  parameter int unsigned DW   = 32,
  parameter              PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;

  logic w_in_beat;
  logic w_out_beat;
  logic w_unused;

  // PROP only tags the instance for implementation flows
  assign w_unused   = ^32'($bits(PROP));

  assign w_in_beat  = in_valid & r_in_ready;
  assign w_out_beat = r_out_valid & out_ready;

  // Occupancy FSM; ready/valid/data are all driven straight from flops
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          r_in_ready <= 1'b1;
          if (w_in_beat) begin
            r_main      <= in_data;
            r_out_valid <= 1'b1;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          case ({w_in_beat, w_out_beat})
            2'b10: begin
              r_skid     <= in_data;
              r_in_ready <= 1'b0;
              r_state    <= ST_FULL;
            end
            2'b01: begin
              r_out_valid <= 1'b0;
              r_state     <= ST_EMPTY;
            end
            2'b11: r_main <= in_data;
            default: ;
          endcase
        end
        ST_FULL: begin
          if (w_out_beat) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_BUSY;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

endmodule

// File: tb/tb_asic_skidbuf.sv
// Self-checking bench for asic_skidbuf: directed vector table, streaming,
// mid-stream reset and a long random run against a queue-based model.
module tb_asic_skidbuf;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          nreset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the buffer as a FIFO of at most two words
  logic [DW-1:0] m_q[$];
  logic          m_ready;
  logic [DW-1:0] m_held;

  always #5 clk = ~clk;

  asic_skidbuf #(.DW(DW), .PROP("DEFAULT")) dut (
    .clk      (clk),
    .nreset   (nreset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ready = 1'b0;
    m_held  = '0;
  endtask

  // One clock edge: advance model, then compare DUT to model and hold rule
  task automatic step();
    logic          mi, mo, stall;
    logic [DW-1:0] prev_data;
    mi        = in_valid & m_ready;
    mo        = (m_q.size() > 0) & out_ready;
    stall     = out_valid & ~out_ready;
    prev_data = out_data;
    @(posedge clk);
    if (mo) void'(m_q.pop_front());
    if (mi) m_q.push_back(in_data);
    m_ready = (m_q.size() < 2);
    if (m_q.size() > 0) m_held = m_q[0];
    #1;
    chk("model_in_ready", DW'(in_ready), DW'(m_ready));
    chk("model_out_valid", DW'(out_valid), DW'(m_q.size() > 0));
    if (m_q.size() > 0) chk("model_out_data", out_data, m_held);
    if (stall) begin
      chk("hold_valid", DW'(out_valid), DW'(1'b1));
      chk("hold_data", out_data, prev_data);
    end
  endtask

  // Asynchronous reset assertion, checked before any clock edge
  task automatic do_reset();
    nreset = 1'b0;
    #1;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_in_ready", DW'(in_ready), '0);
    chk("rst_out_data", out_data, '0);
    model_reset();
    @(posedge clk);
    #1;
    nreset = 1'b1;
    #1;
    chk("rel_in_ready", DW'(in_ready), '0);
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_od;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Reset release, single beat 0xA5, stall/skid 1,2,3, drain from FULL
    tbl[0]  = '{1'b1, 32'hFF, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'hA5, 1'b0, 1'b1, 1'b1, 32'hA5};
    tbl[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'h1,  1'b1, 1'b1, 1'b1, 32'h1};
    tbl[4]  = '{1'b1, 32'h2,  1'b0, 1'b0, 1'b1, 32'h1};
    tbl[5]  = '{1'b1, 32'h3,  1'b1, 1'b1, 1'b1, 32'h2};
    tbl[6]  = '{1'b1, 32'h3,  1'b1, 1'b1, 1'b1, 32'h3};
    tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10};
    tbl[9]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h10};
    tbl[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h10};
    tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h11};
    tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0};

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    nreset    = 1'b1;
    #2;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      step();
      chk($sformatf("vec%0d_in_ready", i), DW'(in_ready), DW'(tbl[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), DW'(out_valid), DW'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_od);
    end

    // Streaming 1..100 at full rate, one-cycle latency
    for (int k = 1; k <= 100; k++) begin
      in_valid  = 1'b1;
      in_data   = DW'(k);
      out_ready = 1'b1;
      step();
      chk("stream_valid", DW'(out_valid), DW'(1'b1));
      chk("stream_data", out_data, DW'(k));
      chk("stream_ready", DW'(in_ready), DW'(1'b1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_valid", DW'(out_valid), '0);

    // Fill to FULL, then reset mid-stream: nothing replayed afterwards
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'hCAFE0001;
    step();
    in_data   = 32'hCAFE0002;
    step();
    chk("pre_rst_full", DW'(in_ready), '0);
    do_reset();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("post_rst_empty", DW'(out_valid), '0);
    chk("post_rst_ready", DW'(in_ready), DW'(1'b1));

    // Random valid/ready traffic
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_data   = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
